banked_ram_responder: RTL and testbench
=======================================

// Module: banked_ram_responder
// PURPOSE
// - Memory-side responder for the per-bank RAM request interface driven by the lockup-free cache banks.
// - Accepts NUM_BANKS level-held read/write requests and arbitrates them round-robin onto one
//   single-ported word array.
// - Returns a one-cycle completion pulse and read data per bank after a fixed LATENCY.
// - Serves as the RAM model behind the cache in system benches.
// PARAMETERS
// - NUM_BANKS  4     request ports; default taken from cache_types_pkg; power of two >= 2
// - LATENCY    4     cycles from grant sample to complete pulse; >= 1
// - MEM_WORDS  1024  32-bit words in the array; power of two
// PORTS
// - CLK               in   1        clock; all logic on rising edge
// - nRST              in   1        reset; synchronous, active-high (1 = reset)
// - ram_mem_REN       in   NB       per-bank read request, held until complete
// - ram_mem_WEN       in   NB       per-bank write request, held until complete
// - ram_mem_addr      in   NBx32    per-bank byte address
// - ram_mem_store     in   NBx32    per-bank write data
// - ram_mem_data      out  NBx32    per-bank read data, registered
// - ram_mem_complete  out  NB       one-cycle completion pulse per bank
// - busy              out  1        high when the FSM is not IDLE
// BEHAVIOUR
// - Reset values: ram_mem_data = 0, ram_mem_complete = 0, busy = 0, FSM = IDLE,
//   RR pointer = 0, counter = 0.
// - The array is not cleared by reset.
// - Word index = addr[$clog2(MEM_WORDS)+1:2]. Upper bits and addr[1:0] are ignored, so
//   out-of-range addresses alias (wrap).
// - Bank b is requesting when REN[b] | WEN[b]. If both are high, the request is a write.
// - FSM IDLE:
//   - With no requests, stay in IDLE.
//   - Otherwise grant the first requesting bank at or after the pointer (mod NUM_BANKS).
//   - Register grant id g, addr, store and rw.
//   - If LATENCY = 1, go to DONE; else counter = LATENCY-2 and go to BUSY.
// - FSM BUSY:
//   - Decrement the counter; at 0, go to DONE.
//   - Inputs are ignored; only the latched request is served.
// - FSM DONE (lasts exactly 1 cycle):
//   - Assert complete[g] = 1.
//   - Write: array[idx] <= store. Read: ram_mem_data[g] <= array[idx], visible in the same
//     cycle as complete (combinational read of the latched index).
//   - Pointer <= (g+1) mod NUM_BANKS; go to IDLE.
// - Latency: a request sampled in IDLE at cycle t completes at cycle t+LATENCY.
//   Max throughput is 1 request per LATENCY+1 cycles.
// - Held requests: the requester drops its request the cycle after complete. Because DONE
//   never arbitrates, a still-high request in the DONE cycle is never re-granted.
// - A request that starts while another is in service waits; there is no queue beyond the
//   level-held inputs.
// - ram_mem_data[b] holds its last read value until bank b's next read completes.
//   Writes leave it unchanged.
// - Request withdrawn mid-service: service still finishes, and complete and the array
//   update still occur.
// - Reset mid-service: the transaction is aborted, no complete is issued, and the array
//   is untouched for that request.
// - Only one complete bit is ever high in a cycle.
// STRUCTURE
// - cache_types_pkg supplies NUM_BANKS and BANKS_LEN.
// - Add to cache_types_pkg: a ram_req_t struct {addr, store, rw} and a resp_state_t enum
//   {IDLE, BUSY, DONE}.
// - One sub-module, rr_arbiter:
//   - Parameter N; inputs req[N] and ptr.
//   - Outputs valid and grant index; purely combinational, reused elsewhere.
// - The array is an inferred single-port RAM in this module.
// TESTING
// - Write then read, LATENCY=4:
//   - WEN[1], addr 0x40, store 0xDEADBEEF at t=0 -> complete[1] at t=4.
//   - REN[1] at 0x40 issued at t=6 -> complete[1] at t=10 with data[1]=0xDEADBEEF.
// - All 4 banks request reads at t=0 -> completes in bank order 0,1,2,3 at t=4,9,14,19.
//   busy stays high except the single IDLE cycle between transactions.
// - Fairness: bank 0 re-requests immediately after every complete while bank 2 holds a
//   request -> grants alternate 0,2,0,2.
// - nRST=1 at t=2 of a bank-3 write to 0x10 -> no complete[3]; a later read of 0x10
//   returns its old value; all outputs are 0 after reset.
// - REN[2] and WEN[2] both high, store 0x1234 at 0x8 -> treated as a write.
//   Reading 0x8 returns 0x1234.
// - Alias, MEM_WORDS=1024: write 0xA5A5A5A5 to addr 0x1000 -> read of addr 0x0 returns
//   0xA5A5A5A5. LATENCY=1 run: complete exactly 1 cycle after grant.

Source files
------------

// File: rtl/cache_types_pkg.sv
// Shared cache/RAM types: bank count, RAM request bundle
// and responder FSM states.
package cache_types_pkg;

  localparam int NUM_BANKS = 4;
  localparam int BANKS_LEN = $clog2(NUM_BANKS);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] store;
    logic        rw;
  } ram_req_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } resp_state_t;

endpackage

// File: rtl/banked_ram_responder_if.sv
// Per-bank RAM request/response bundle between the
// cache banks (master) and the RAM responder (slave).
interface banked_ram_responder_if #(
  parameter int NB = 4
);

  logic [NB-1:0]       ram_mem_REN;
  logic [NB-1:0]       ram_mem_WEN;
  logic [NB-1:0][31:0] ram_mem_addr;
  logic [NB-1:0][31:0] ram_mem_store;
  logic [NB-1:0][31:0] ram_mem_data;
  logic [NB-1:0]       ram_mem_complete;

  modport master (
    output ram_mem_REN,
    output ram_mem_WEN,
    output ram_mem_addr,
    output ram_mem_store,
    input  ram_mem_data,
    input  ram_mem_complete
  );

  modport slave (
    input  ram_mem_REN,
    input  ram_mem_WEN,
    input  ram_mem_addr,
    input  ram_mem_store,
    output ram_mem_data,
    output ram_mem_complete
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester
// at or after ptr_i, wrapping modulo N (N a power of two).
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         valid_o,
  output logic [W-1:0] grant_o
);

  logic [W-1:0] idx;

  // Scan from the farthest offset down so the
  // nearest requester to the pointer wins last.
  always_comb begin
    valid_o = 1'b0;
    grant_o = '0;
    idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ptr_i + W'(i);
      if (req_i[idx]) begin
        valid_o = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/banked_ram_responder.sv
// RAM model behind the cache banks: round-robin service of
// level-held per-bank requests with fixed completion latency.
module banked_ram_responder #(
  parameter int NUM_BANKS = cache_types_pkg::NUM_BANKS,
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 1024
) (
  input  logic                 CLK,
  input  logic                 nRST,
  banked_ram_responder_if.slave bus,
  output logic                 busy
);

  import cache_types_pkg::*;

  localparam int IW = $clog2(MEM_WORDS);
  localparam int PW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  resp_state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ram_req_t      req_q, req_d;

  logic [NUM_BANKS-1:0]       complete_q, complete_d;
  logic [NUM_BANKS-1:0][31:0] data_q;
  logic [31:0]                mem_q [MEM_WORDS];

  logic [NUM_BANKS-1:0] req_vec;
  logic                 arb_valid;
  logic [PW-1:0]        arb_grant;
  logic                 done_go;
  logic [IW-1:0]        idx_d;
  logic [31:0]          rd_word;
  logic                 unused_addr_bits;

  assign req_vec = bus.ram_mem_REN | bus.ram_mem_WEN;

  rr_arbiter #(
    .N(NUM_BANKS)
  ) u_arb (
    .req_i  (req_vec),
    .ptr_i  (ptr_q),
    .valid_o(arb_valid),
    .grant_o(arb_grant)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    complete_d = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d       = arb_grant;
          req_d.addr  = bus.ram_mem_addr[arb_grant];
          req_d.store = bus.ram_mem_store[arb_grant];
          req_d.rw    = bus.ram_mem_WEN[arb_grant];
          if (LATENCY == 1) begin
            state_d = DONE;
          end else begin
            cnt_d   = CW'(LATENCY - 2);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = DONE;
        else cnt_d = cnt_q - CW'(1);
      end
      DONE: begin
        ptr_d   = gnt_q + PW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DONE) complete_d[gnt_d] = 1'b1;
  end

  // The access is performed on the edge entering DONE so
  // data and complete become visible in the same cycle.
  assign done_go = (state_d == DONE);
  assign idx_d   = req_d.addr[IW+1:2];
  assign rd_word = mem_q[idx_d];
  assign unused_addr_bits =
    ^{req_d.addr[31:IW+2], req_d.addr[1:0]};

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      cnt_q      <= '0;
      req_q      <= '0;
      complete_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      complete_q <= complete_d;
      if (done_go && !req_d.rw) data_q[gnt_d] <= rd_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST && done_go && req_d.rw) mem_q[idx_d] <= req_d.store;
  end

  assign bus.ram_mem_data     = data_q;
  assign bus.ram_mem_complete = complete_q;
  assign busy                 = (state_q != IDLE);

endmodule

// File: tb/tb_banked_ram_responder.sv
// Directed bench for banked_ram_responder: one LATENCY=4
// instance and one LATENCY=1 instance on a shared clock/reset.
module tb_banked_ram_responder;

  logic CLK = 1'b0;
  logic nRST;
  logic busy_a, busy_b;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  banked_ram_responder_if #(.NB(4)) ifa ();
  banked_ram_responder_if #(.NB(4)) ifb ();

  banked_ram_responder #(
    .NUM_BANKS(4), .LATENCY(4), .MEM_WORDS(1024)
  ) dut_a (
    .CLK(CLK), .nRST(nRST), .bus(ifa), .busy(busy_a)
  );

  banked_ram_responder #(
    .NUM_BANKS(4), .LATENCY(1), .MEM_WORDS(1024)
  ) dut_b (
    .CLK(CLK), .nRST(nRST), .bus(ifb), .busy(busy_b)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ifa.ram_mem_REN   = '0;
    ifa.ram_mem_WEN   = '0;
    ifa.ram_mem_addr  = '0;
    ifa.ram_mem_store = '0;
    ifb.ram_mem_REN   = '0;
    ifb.ram_mem_WEN   = '0;
    ifb.ram_mem_addr  = '0;
    ifb.ram_mem_store = '0;
  endtask

  task automatic wait_idle(input bit fast);
    int k = 0;
    while ((fast ? busy_b : busy_a) && k < 30) begin
      step();
      k++;
    end
  endtask

  task automatic drive(input bit fast, input int b,
                       input bit w, input bit r,
                       input logic [31:0] a,
                       input logic [31:0] s);
    if (fast) begin
      ifb.ram_mem_WEN[b]   = w;
      ifb.ram_mem_REN[b]   = r;
      ifb.ram_mem_addr[b]  = a;
      ifb.ram_mem_store[b] = s;
    end else begin
      ifa.ram_mem_WEN[b]   = w;
      ifa.ram_mem_REN[b]   = r;
      ifa.ram_mem_addr[b]  = a;
      ifa.ram_mem_store[b] = s;
    end
  endtask

  // Issue one request from an idle responder; lat is the
  // cycles from drive to complete, -1 if it never arrives.
  task automatic txn(input bit fast, input int b,
                     input bit w, input bit r,
                     input logic [31:0] a,
                     input logic [31:0] s,
                     output int lat,
                     output logic [31:0] d);
    int c;
    logic cmp;
    wait_idle(fast);
    drive(fast, b, w, r, a, s);
    c   = cyc;
    lat = -1;
    d   = 'x;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      step();
      cmp = fast ? ifb.ram_mem_complete[b]
                 : ifa.ram_mem_complete[b];
      if (cmp) begin
        lat = cyc - c;
        d   = fast ? ifb.ram_mem_data[b] : ifa.ram_mem_data[b];
      end
    end
    drive(fast, b, 1'b0, 1'b0, a, s);
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    clear_inputs();
    repeat (3) step();
    total++;
    if (busy_a !== 1'b0) begin
      bad++; $display("FAIL rst_busy_a: got %b want 0", busy_a);
    end
    total++;
    if (busy_b !== 1'b0) begin
      bad++; $display("FAIL rst_busy_b: got %b want 0", busy_b);
    end
    total++;
    if (ifa.ram_mem_complete !== 4'b0) begin
      bad++;
      $display("FAIL rst_cmp_a: got %b want 0", ifa.ram_mem_complete);
    end
    total++;
    if (ifb.ram_mem_complete !== 4'b0) begin
      bad++;
      $display("FAIL rst_cmp_b: got %b want 0", ifb.ram_mem_complete);
    end
    total++;
    if (ifa.ram_mem_data !== 128'h0) begin
      bad++; $display("FAIL rst_data_a: got %h want 0", ifa.ram_mem_data);
    end
    total++;
    if (ifb.ram_mem_data !== 128'h0) begin
      bad++; $display("FAIL rst_data_b: got %h want 0", ifb.ram_mem_data);
    end
    nRST = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    int lat;
    logic [31:0] d;
    txn(1'b0, 1, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, lat, d);
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL wr_lat: got %0d want 4", lat);
    end
    total++;
    if (ifa.ram_mem_data[1] !== 32'h0) begin
      bad++;
      $display("FAIL wr_keeps_data: got %h want 0", ifa.ram_mem_data[1]);
    end
    txn(1'b0, 1, 1'b0, 1'b1, 32'h40, 32'h0, lat, d);
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL rd_lat: got %0d want 4", lat);
    end
    total++;
    if (d !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rd_data: got %h want deadbeef", d);
    end
  endtask

  task automatic test_all_banks();
    int lat, c, ndone, busy_low, multi;
    int t_done [4];
    logic [31:0] d;
    logic [31:0] dat [4];
    for (int b = 0; b < 4; b++)
      txn(1'b0, b, 1'b1, 1'b0, 32'h100 + 32'(16 * b),
          32'hC0DE0000 + 32'(b), lat, d);
    wait_idle(1'b0);
    for (int b = 0; b < 4; b++) begin
      drive(1'b0, b, 1'b0, 1'b1, 32'h100 + 32'(16 * b), 32'h0);
      t_done[b] = -1;
      dat[b]    = 'x;
    end
    c = cyc;
    ndone = 0;
    busy_low = 0;
    multi = 0;
    for (int k = 0; k < 40 && ndone < 4; k++) begin
      step();
      if ($countones(ifa.ram_mem_complete) > 1) multi++;
      if (!busy_a) busy_low++;
      for (int b = 0; b < 4; b++) begin
        if (ifa.ram_mem_complete[b]) begin
          t_done[b] = cyc - c;
          dat[b]    = ifa.ram_mem_data[b];
          ifa.ram_mem_REN[b] = 1'b0;
          ndone++;
        end
      end
    end
    for (int b = 0; b < 4; b++) begin
      total++;
      if (t_done[b] !== 4 + 5 * b) begin
        bad++;
        $display("FAIL all_t%0d: got %0d want %0d",
                 b, t_done[b], 4 + 5 * b);
      end
      total++;
      if (dat[b] !== 32'hC0DE0000 + 32'(b)) begin
        bad++;
        $display("FAIL all_d%0d: got %h want %h",
                 b, dat[b], 32'hC0DE0000 + 32'(b));
      end
    end
    total++;
    if (multi !== 0) begin
      bad++; $display("FAIL onehot: got %0d multi cycles want 0", multi);
    end
    total++;
    if (busy_low !== 3) begin
      bad++; $display("FAIL busy_gaps: got %0d want 3", busy_low);
    end
  endtask

  task automatic test_fairness();
    int n;
    int ord [4];
    int exp_ord [4] = '{0, 2, 0, 2};
    nRST = 1'b1;
    step();
    nRST = 1'b0;
    step();
    for (int i = 0; i < 4; i++) ord[i] = -1;
    drive(1'b0, 0, 1'b0, 1'b1, 32'h100, 32'h0);
    drive(1'b0, 2, 1'b0, 1'b1, 32'h120, 32'h0);
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      step();
      for (int b = 0; b < 4; b++) begin
        if (ifa.ram_mem_complete[b] && n < 4) begin
          ord[n] = b;
          n++;
        end
      end
    end
    ifa.ram_mem_REN = '0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ord[i] !== exp_ord[i]) begin
        bad++;
        $display("FAIL fair_%0d: got bank %0d want %0d",
                 i, ord[i], exp_ord[i]);
      end
    end
    total++;
    if (ifa.ram_mem_data[2] !== 32'hC0DE0002) begin
      bad++;
      $display("FAIL fair_d2: got %h want c0de0002", ifa.ram_mem_data[2]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit saw;
    logic [31:0] d;
    txn(1'b0, 0, 1'b1, 1'b0, 32'h10, 32'h11112222, lat, d);
    wait_idle(1'b0);
    drive(1'b0, 3, 1'b1, 1'b0, 32'h10, 32'h99999999);
    step();
    step();
    nRST = 1'b1;
    ifa.ram_mem_WEN[3] = 1'b0;
    step();
    total++;
    if (ifa.ram_mem_complete !== 4'b0) begin
      bad++;
      $display("FAIL mid_cmp: got %b want 0", ifa.ram_mem_complete);
    end
    total++;
    if (ifa.ram_mem_data !== 128'h0) begin
      bad++; $display("FAIL mid_data: got %h want 0", ifa.ram_mem_data);
    end
    total++;
    if (busy_a !== 1'b0) begin
      bad++; $display("FAIL mid_busy: got %b want 0", busy_a);
    end
    nRST = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      step();
      if (ifa.ram_mem_complete[3]) saw = 1'b1;
    end
    total++;
    if (saw !== 1'b0) begin
      bad++; $display("FAIL mid_late_cmp: got %b want 0", saw);
    end
    txn(1'b0, 3, 1'b0, 1'b1, 32'h10, 32'h0, lat, d);
    total++;
    if (d !== 32'h11112222) begin
      bad++; $display("FAIL mid_old: got %h want 11112222", d);
    end
  endtask

  task automatic test_rw_both();
    int lat;
    logic [31:0] d;
    txn(1'b0, 2, 1'b1, 1'b1, 32'h8, 32'h1234, lat, d);
    total++;
    if (ifa.ram_mem_data[2] !== 32'h0) begin
      bad++;
      $display("FAIL rw_data_kept: got %h want 0", ifa.ram_mem_data[2]);
    end
    txn(1'b0, 2, 1'b0, 1'b1, 32'h8, 32'h0, lat, d);
    total++;
    if (d !== 32'h1234) begin
      bad++; $display("FAIL rw_as_write: got %h want 1234", d);
    end
  endtask

  task automatic test_alias();
    int lat;
    logic [31:0] d;
    txn(1'b0, 0, 1'b1, 1'b0, 32'h1000, 32'hA5A5A5A5, lat, d);
    txn(1'b0, 1, 1'b0, 1'b1, 32'h0, 32'h0, lat, d);
    total++;
    if (d !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL alias_wrap: got %h want a5a5a5a5", d);
    end
    txn(1'b0, 3, 1'b0, 1'b1, 32'h3, 32'h0, lat, d);
    total++;
    if (d !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL alias_lsb: got %h want a5a5a5a5", d);
    end
  endtask

  task automatic test_withdrawn();
    int lat, c;
    logic [31:0] d;
    wait_idle(1'b0);
    drive(1'b0, 0, 1'b1, 1'b0, 32'h20, 32'h77);
    c = cyc;
    step();
    ifa.ram_mem_WEN[0] = 1'b0;
    lat = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      if (ifa.ram_mem_complete[0]) lat = cyc - c;
      else step();
    end
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL wd_lat: got %0d want 4", lat);
    end
    txn(1'b0, 0, 1'b0, 1'b1, 32'h20, 32'h0, lat, d);
    total++;
    if (d !== 32'h77) begin
      bad++; $display("FAIL wd_data: got %h want 77", d);
    end
  endtask

  task automatic test_latency1();
    int lat;
    logic [31:0] d;
    txn(1'b1, 1, 1'b1, 1'b0, 32'h40, 32'hCAFEF00D, lat, d);
    total++;
    if (lat !== 1) begin
      bad++; $display("FAIL l1_wr_lat: got %0d want 1", lat);
    end
    step();
    total++;
    if (ifb.ram_mem_complete !== 4'b0) begin
      bad++;
      $display("FAIL l1_pulse: got %b want 0", ifb.ram_mem_complete);
    end
    txn(1'b1, 1, 1'b0, 1'b1, 32'h40, 32'h0, lat, d);
    total++;
    if (lat !== 1) begin
      bad++; $display("FAIL l1_rd_lat: got %0d want 1", lat);
    end
    total++;
    if (d !== 32'hCAFEF00D) begin
      bad++; $display("FAIL l1_rd_data: got %h want cafef00d", d);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_all_banks();
    test_fairness();
    test_reset_mid();
    test_rw_both();
    test_alias();
    test_withdrawn();
    test_latency1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
